// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Final pipeline stage. Selects the write-back value (ALU result or
//            load data), owns the architectural register file with two
//            combinational read ports (with write-through bypass), keeps the
//            per-register busy scoreboard used by decode, and publishes a
//            registered forwarding bus plus a retired-instruction counter.
// Ports    : I_CLOCK        - stage clock, state updates on the falling edge
//            I_LOCK         - asynchronous active-low reset (0 = held)
//            I_Opcode       - opcode from the memory stage
//            I_ALUOut       - ALU result from the memory stage
//            I_MemOut       - load data from the memory stage
//            I_DestRegIdx   - destination register index
//            I_FetchStall   - bubble marker
//            I_DepStall     - bubble marker
//            I_RdIdxA/B     - decode read-port indices
//            I_SetBusy      - decode issued a register-writing instruction
//            I_SetBusyIdx   - destination of that instruction
//            O_RdDataA/B    - read-port data (combinational, bypassed)
//            O_Busy         - scoreboard, bit i = write to Ri pending
//            O_WBValid      - registered: a write retired this cycle
//            O_WBRegIdx     - registered index of that write
//            O_WBValue      - registered value of that write
//            O_RetireCount  - count of non-bubble instructions retired
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int NUM_REGS     = 16,
  parameter int IDX_WIDTH    = 4,
  parameter int REG_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    I_CLOCK,
  input  logic                    I_LOCK,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [REG_WIDTH-1:0]    I_MemOut,
  input  logic [IDX_WIDTH-1:0]    I_DestRegIdx,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  input  logic [IDX_WIDTH-1:0]    I_RdIdxA,
  input  logic [IDX_WIDTH-1:0]    I_RdIdxB,
  input  logic                    I_SetBusy,
  input  logic [IDX_WIDTH-1:0]    I_SetBusyIdx,
  output logic [REG_WIDTH-1:0]    O_RdDataA,
  output logic [REG_WIDTH-1:0]    O_RdDataB,
  output logic [NUM_REGS-1:0]     O_Busy,
  output logic                    O_WBValid,
  output logic [IDX_WIDTH-1:0]    O_WBRegIdx,
  output logic [REG_WIDTH-1:0]    O_WBValue,
  output logic [CNT_WIDTH-1:0]    O_RetireCount
);

  // Opcode encodings shared with the rest of the pipeline.
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D  = OPCODE_WIDTH'(8'h01);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D = OPCODE_WIDTH'(8'h03);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND_D  = OPCODE_WIDTH'(8'h05);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI_D = OPCODE_WIDTH'(8'h07);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV    = OPCODE_WIDTH'(8'h09);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_D = OPCODE_WIDTH'(8'h0B);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW    = OPCODE_WIDTH'(8'h10);
  localparam logic [OPCODE_WIDTH-1:0] OP_JSR    = OPCODE_WIDTH'(8'h2A);
  localparam logic [OPCODE_WIDTH-1:0] OP_JSRR   = OPCODE_WIDTH'(8'h2B);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [REG_WIDTH-1:0] rf_q [NUM_REGS];
  logic [REG_WIDTH-1:0] rf_d [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q,     busy_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [IDX_WIDTH-1:0] wb_idx_q,   wb_idx_d;
  logic [REG_WIDTH-1:0] wb_value_q, wb_value_d;
  logic [CNT_WIDTH-1:0] count_q,    count_d;

  // --------------------------------------------------------------------------
  // Decode of the incoming instruction
  // --------------------------------------------------------------------------
  logic                 valid;
  logic                 we;
  logic                 is_load;
  logic                 do_write;
  logic [REG_WIDTH-1:0] wr_value;

  // I_LOCK is folded in so the read-port bypass is also suppressed in reset.
  assign valid = I_LOCK & ~I_FetchStall & ~I_DepStall;

  always_comb begin
    we      = 1'b0;
    is_load = 1'b0;
    case (I_Opcode)
      OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D,
      OP_MOV, OP_MOVI_D, OP_JSR, OP_JSRR: we = 1'b1;
      OP_LDW: begin
        we      = 1'b1;
        is_load = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign do_write = valid & we;
  assign wr_value = is_load ? I_MemOut : I_ALUOut;

  // --------------------------------------------------------------------------
  // Register file next state and read ports
  // --------------------------------------------------------------------------
  always_comb begin
    rf_d = rf_q;
    if (do_write) begin
      rf_d[I_DestRegIdx] = wr_value;
    end
  end

  // Write-through: a reader in the same cycle as the producer retires sees
  // the incoming value rather than the stale entry.
  assign O_RdDataA = (do_write && (I_DestRegIdx == I_RdIdxA)) ? wr_value : rf_q[I_RdIdxA];
  assign O_RdDataB = (do_write && (I_DestRegIdx == I_RdIdxB)) ? wr_value : rf_q[I_RdIdxB];

  // --------------------------------------------------------------------------
  // Scoreboard: a newly issued producer wins over the retiring one, so a
  // same-cycle set and clear on one register leaves it busy.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      logic set_bit;
      logic clr_bit;
      assign set_bit = I_SetBusy & (I_SetBusyIdx == IDX_WIDTH'(gi));
      assign clr_bit = do_write & (I_DestRegIdx == IDX_WIDTH'(gi));
      assign busy_d[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_q[gi]);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Forwarding bus and retire counter. Non-writing instructions still retire
  // and publish their index with a zero value; bubbles leave index/value as is.
  // --------------------------------------------------------------------------
  always_comb begin
    wb_valid_d = do_write;
    wb_idx_d   = wb_idx_q;
    wb_value_d = wb_value_q;
    count_d    = count_q;
    if (valid) begin
      wb_idx_d   = I_DestRegIdx;
      wb_value_d = we ? wr_value : '0;
      count_d    = count_q + CNT_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Falling-edge state update, asynchronous reset
  // --------------------------------------------------------------------------
  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
      busy_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_value_q <= '0;
      count_q    <= '0;
    end else begin
      rf_q       <= rf_d;
      busy_q     <= busy_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_value_q <= wb_value_d;
      count_q    <= count_d;
    end
  end

  assign O_Busy        = busy_q;
  assign O_WBValid     = wb_valid_q;
  assign O_WBRegIdx    = wb_idx_q;
  assign O_WBValue     = wb_value_q;
  assign O_RetireCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Self-checking bench for writeback_stage: directed vector table,
//            hand-written reset / scoreboard / counter-wrap sequences, and a
//            randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  localparam logic [7:0] OP_ADD_D  = 8'h01;
  localparam logic [7:0] OP_ADDI_D = 8'h03;
  localparam logic [7:0] OP_AND_D  = 8'h05;
  localparam logic [7:0] OP_ANDI_D = 8'h07;
  localparam logic [7:0] OP_MOV    = 8'h09;
  localparam logic [7:0] OP_MOVI_D = 8'h0B;
  localparam logic [7:0] OP_LDW    = 8'h10;
  localparam logic [7:0] OP_STW    = 8'h11;
  localparam logic [7:0] OP_BRZ    = 8'h20;
  localparam logic [7:0] OP_JMP    = 8'h28;
  localparam logic [7:0] OP_JSR    = 8'h2A;
  localparam logic [7:0] OP_JSRR   = 8'h2B;
  localparam logic [7:0] OP_UNK    = 8'hFF;

  logic        clk = 1'b1;
  logic        lock;
  logic [7:0]  op;
  logic [15:0] alu, mem;
  logic [3:0]  dest, ra, rb, sbi;
  logic        fs, ds, sb;
  logic [15:0] rda, rdb, busy, wbval, cnt;
  logic        wbv;
  logic [3:0]  wbidx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .I_CLOCK      (clk),
    .I_LOCK       (lock),
    .I_Opcode     (op),
    .I_ALUOut     (alu),
    .I_MemOut     (mem),
    .I_DestRegIdx (dest),
    .I_FetchStall (fs),
    .I_DepStall   (ds),
    .I_RdIdxA     (ra),
    .I_RdIdxB     (rb),
    .I_SetBusy    (sb),
    .I_SetBusyIdx (sbi),
    .O_RdDataA    (rda),
    .O_RdDataB    (rdb),
    .O_Busy       (busy),
    .O_WBValid    (wbv),
    .O_WBRegIdx   (wbidx),
    .O_WBValue    (wbval),
    .O_RetireCount(cnt)
  );

  // ---------------------------------------------------------------- model
  logic [15:0] m_rf [16];
  logic [15:0] m_busy;
  logic        m_wbv;
  logic [3:0]  m_wbidx;
  logic [15:0] m_wbval;
  logic [15:0] m_cnt;

  function automatic bit writes(logic [7:0] o);
    return o inside {OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D, OP_MOV,
                     OP_MOVI_D, OP_JSR, OP_JSRR, OP_LDW};
  endfunction

  function automatic logic [15:0] wval();
    return (op == OP_LDW) ? mem : alu;
  endfunction

  function automatic bit m_valid();
    return lock && !fs && !ds;
  endfunction

  function automatic logic [15:0] m_read(logic [3:0] idx);
    if (m_valid() && writes(op) && dest == idx) return wval();
    return m_rf[idx];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_busy = '0; m_wbv = 1'b0; m_wbidx = '0; m_wbval = '0; m_cnt = '0;
  endfunction

  function automatic void model_edge();
    logic [15:0] nb;
    if (!lock) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 16; i++) begin
      if (sb && sbi == i)                                nb[i] = 1'b1;
      else if (m_valid() && writes(op) && dest == i)     nb[i] = 1'b0;
      else                                               nb[i] = m_busy[i];
    end
    m_busy = nb;
    m_wbv  = m_valid() && writes(op);
    if (m_valid()) begin
      if (writes(op)) m_rf[dest] = wval();
      m_wbidx = dest;
      m_wbval = writes(op) ? wval() : 16'h0;
      m_cnt   = m_cnt + 16'h1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance through one falling edge and sample just after it.
  task automatic step();
    @(negedge clk);
    model_edge();
    #1;
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic [7:0]  op;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [3:0]  dest;
    logic        fs;
    logic        ds;
    logic        ev;
    logic [3:0]  eidx;
    logic [15:0] eval;
    logic [15:0] erda;
    logic [15:0] erdb;
    logic [15:0] ecnt;
    logic [15:0] erf;
  } vec_t;

  vec_t tbl [8];

  logic [7:0] pool [13];

  initial begin
    pool = '{OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D, OP_MOV, OP_MOVI_D, OP_LDW,
             OP_STW, OP_BRZ, OP_JMP, OP_JSR, OP_JSRR, OP_UNK};

    //          op         alu      mem      dst fs ds  ev eidx eval     erda     erdb     ecnt  erf
    tbl[0] = '{OP_ADD_D,  16'h1234, 16'h0000, 3, 0, 0,  1, 3, 16'h1234, 16'h1234, 16'h1234, 1, 16'h1234};
    tbl[1] = '{OP_LDW,    16'hAAAA, 16'h0042, 5, 0, 0,  1, 5, 16'h0042, 16'h0042, 16'h1234, 2, 16'h0042};
    tbl[2] = '{OP_STW,    16'h1111, 16'h2222, 6, 0, 0,  0, 6, 16'h0000, 16'h0000, 16'h1234, 3, 16'h0000};
    tbl[3] = '{OP_BRZ,    16'h3333, 16'h4444, 2, 0, 0,  0, 2, 16'h0000, 16'h0000, 16'h1234, 4, 16'h0000};
    tbl[4] = '{OP_ADD_D,  16'h7777, 16'h0000, 7, 0, 1,  0, 2, 16'h0000, 16'h0000, 16'h1234, 4, 16'h0000};
    tbl[5] = '{OP_MOV,    16'hBEEF, 16'h0000, 0, 1, 0,  0, 2, 16'h0000, 16'h0000, 16'h1234, 4, 16'h0000};
    tbl[6] = '{OP_MOVI_D, 16'hBEEF, 16'h0000, 0, 0, 0,  1, 0, 16'hBEEF, 16'hBEEF, 16'h1234, 5, 16'hBEEF};
    tbl[7] = '{OP_JSRR,   16'h00FF, 16'h5555, 15, 0, 0, 1, 15, 16'h00FF, 16'h00FF, 16'h1234, 6, 16'h00FF};

    // ---- reset state
    lock = 1'b0; op = OP_STW; alu = '0; mem = '0; dest = '0; fs = 1'b1; ds = 1'b0;
    ra = 4'd3; rb = 4'd5; sb = 1'b1; sbi = 4'd9;
    model_reset();
    step();  // edge with I_SetBusy asserted while held in reset
    chk("reset_busy", busy, 16'h0);
    chk("reset_cnt", cnt, 16'h0);
    chk("reset_wbv", wbv, 1'b0);
    chk("reset_rda", rda, 16'h0);
    @(posedge clk); #1;
    lock = 1'b1; sb = 1'b0;

    // ---- directed table
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      op = tbl[k].op; alu = tbl[k].alu; mem = tbl[k].mem; dest = tbl[k].dest;
      fs = tbl[k].fs; ds = tbl[k].ds; ra = tbl[k].dest; rb = 4'd3; sb = 1'b0;
      #1;
      chk("tbl_bypass_a", rda, tbl[k].erda);
      chk("tbl_rd_b", rdb, tbl[k].erdb);
      step();
      chk("tbl_wbvalid", wbv, tbl[k].ev);
      chk("tbl_wbidx", wbidx, tbl[k].eidx);
      chk("tbl_wbvalue", wbval, tbl[k].eval);
      chk("tbl_count", cnt, tbl[k].ecnt);
      chk("tbl_busy", busy, 16'h0);
      fs = 1'b1; #1;
      chk("tbl_rf", rda, tbl[k].erf);
    end

    // ---- asynchronous reset mid-cycle, no clock edge in between
    @(posedge clk); #3;
    lock = 1'b0; model_reset();
    #1;
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i); #1;
      chk("async_rst_rf", rda, 16'h0);
    end
    chk("async_rst_busy", busy, 16'h0);
    chk("async_rst_cnt", cnt, 16'h0);
    chk("async_rst_wbv", wbv, 1'b0);
    @(posedge clk); #1;
    lock = 1'b1;

    // ---- scoreboard corner cases
    op = OP_STW; fs = 1'b1; ds = 1'b0; sb = 1'b1; sbi = 4'd4; dest = 4'd4;
    step();
    chk("sb_set4", busy[4], 1'b1);
    @(posedge clk); #1;
    op = OP_MOV; alu = 16'h4444; fs = 1'b0; sb = 1'b1; sbi = 4'd4;
    step();
    chk("sb_set_wins", busy[4], 1'b1);
    chk("sb_mov_wbv", wbv, 1'b1);
    @(posedge clk); #1;
    op = OP_ADD_D; alu = 16'h0005; sb = 1'b0;
    step();
    chk("sb_clear4", busy[4], 1'b0);
    chk("sb_cnt", cnt, 16'd2);
    @(posedge clk); #1;
    fs = 1'b1; sb = 1'b1; sbi = 4'd9;
    step();
    step();
    chk("sb_double_set", busy, 16'h0200);
    sb = 1'b0;

    // ---- randomized run against the model
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      op   = pool[$urandom_range(0, 12)];
      alu  = 16'($urandom);
      mem  = 16'($urandom);
      dest = 4'($urandom);
      fs   = ($urandom_range(0, 7) == 0);
      ds   = ($urandom_range(0, 7) == 0);
      ra   = ($urandom_range(0, 2) == 0) ? dest : 4'($urandom);
      rb   = 4'($urandom);
      sb   = ($urandom_range(0, 3) == 0);
      sbi  = 4'($urandom);
      #1;
      chk("rnd_rda", rda, m_read(ra));
      chk("rnd_rdb", rdb, m_read(rb));
      step();
      chk("rnd_wbv", wbv, m_wbv);
      chk("rnd_wbidx", wbidx, m_wbidx);
      chk("rnd_wbval", wbval, m_wbval);
      chk("rnd_cnt", cnt, m_cnt);
      chk("rnd_busy", busy, m_busy);
    end

    // ---- retire counter wrap
    @(posedge clk); #1;
    lock = 1'b0; model_reset();
    #2;
    lock = 1'b1;
    op = OP_STW; fs = 1'b0; ds = 1'b0; sb = 1'b0;
    repeat (65535) step();
    chk("cnt_max", cnt, 16'hFFFF);
    step();
    chk("cnt_wrap", cnt, 16'h0000);
    chk("cnt_wrap_model", cnt, m_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
